// File: rtl/stage_4_mem.sv
// stage_4_mem: pipeline stage 4, word loads/stores over a req/gnt/rvalid bus, stalling stages 1-3
// Ports: clk (all state on negedge), reset (async, active-high);
//   from stage 3: alu_res, rs2_val, rd_idx, mem_load_enable, mem_store_enable, reg_write_enable,
//   jump_enable, jump_address;
//   data memory: mem_req, mem_we, mem_addr, mem_wdata out; mem_gnt, mem_rvalid, mem_rdata in;
//   stall_out (combinational) to stages 1-3;
//   to stage 5 / fetch: wb_data_out, wb_rd_idx_out, wb_reg_write_enable_out, jump_enable_out,
//   jump_address_out, mem_error_out (sticky).
module stage_4_mem #(
  parameter int unsigned WAIT_LIMIT = 255,
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] alu_res,
  input  logic [31:0] rs2_val,
  input  logic [4:0]  rd_idx,
  input  logic        mem_load_enable,
  input  logic        mem_store_enable,
  input  logic        reg_write_enable,
  input  logic        jump_enable,
  input  logic [31:0] jump_address,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        stall_out,
  output logic [31:0] wb_data_out,
  output logic [4:0]  wb_rd_idx_out,
  output logic        wb_reg_write_enable_out,
  output logic        jump_enable_out,
  output logic [31:0] jump_address_out,
  output logic        mem_error_out
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d, cnt_q, cnt_d;
  logic [31:0] wb_data_q, wb_data_d, jaddr_q, jaddr_d;
  logic [4:0] rd_q, rd_d, wb_rd_q, wb_rd_d;
  logic we_q, we_d, rwe_q, rwe_d, abort_q, abort_d;
  logic wb_we_q, wb_we_d, jen_q, jen_d, err_q, err_d;
  logic memop, misal, tmo;
  assign memop = mem_load_enable | mem_store_enable;
  assign misal = ALIGN_CHECK && (alu_res[1:0] != 2'b00);
  // cnt_q holds the negedges already spent in REQ/WAIT, so the current one is number cnt_q+1
  assign tmo = (WAIT_LIMIT != 0) && (cnt_q + 32'd1 >= WAIT_LIMIT);
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d = cnt_q;
    wb_data_d = wb_data_q;
    jaddr_d = jaddr_q;
    rd_d = rd_q;
    wb_rd_d = wb_rd_q;
    we_d = we_q;
    rwe_d = rwe_q;
    abort_d = abort_q;
    wb_we_d = wb_we_q;
    jen_d = jen_q;
    err_d = err_q;
    case (state_q)
      IDLE: begin
        if (!memop) begin
          wb_data_d = alu_res;
          wb_rd_d = rd_idx;
          wb_we_d = reg_write_enable;
          jen_d = jump_enable;
          jaddr_d = jump_address;
        end else begin
          addr_d = alu_res;
          wdata_d = rs2_val;
          we_d = mem_store_enable;
          rd_d = rd_idx;
          rwe_d = reg_write_enable;
          cnt_d = '0;
          wb_we_d = 1'b0;
          jen_d = 1'b0;
          abort_d = misal;
          err_d = err_q | misal;
          state_d = misal ? DONE : REQ;
        end
      end
      REQ: begin
        wb_we_d = 1'b0;
        jen_d = 1'b0;
        cnt_d = cnt_q + 32'd1;
        // a load whose data arrives together with the grant skips WAIT
        if (mem_gnt && (we_q || mem_rvalid)) begin
          rdata_d = mem_rdata;
          state_d = DONE;
        end else if (mem_gnt) begin
          state_d = WAIT;
        end else if (tmo) begin
          abort_d = 1'b1;
          err_d = 1'b1;
          state_d = DONE;
        end
      end
      WAIT: begin
        wb_we_d = 1'b0;
        jen_d = 1'b0;
        cnt_d = cnt_q + 32'd1;
        if (mem_rvalid) begin
          rdata_d = mem_rdata;
          state_d = DONE;
        end else if (tmo) begin
          abort_d = 1'b1;
          err_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        wb_data_d = rdata_q;
        wb_rd_d = rd_q;
        wb_we_d = rwe_q & ~we_q & ~abort_q;
        jen_d = jump_enable & ~abort_q;
        jaddr_d = jump_address;
        abort_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q <= '0;
      wb_data_q <= '0;
      jaddr_q <= '0;
      rd_q <= '0;
      wb_rd_q <= '0;
      we_q <= 1'b0;
      rwe_q <= 1'b0;
      abort_q <= 1'b0;
      wb_we_q <= 1'b0;
      jen_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q <= cnt_d;
      wb_data_q <= wb_data_d;
      jaddr_q <= jaddr_d;
      rd_q <= rd_d;
      wb_rd_q <= wb_rd_d;
      we_q <= we_d;
      rwe_q <= rwe_d;
      abort_q <= abort_d;
      wb_we_q <= wb_we_d;
      jen_q <= jen_d;
      err_q <= err_d;
    end
  end
  assign mem_req = state_q == REQ;
  assign mem_we = we_q;
  assign mem_addr = addr_q;
  assign mem_wdata = wdata_q;
  // DONE releases the stall so stage 3 advances on the same negedge that retires the access
  assign stall_out = ~reset & ((state_q == REQ) | (state_q == WAIT) | ((state_q == IDLE) & memop));
  assign wb_data_out = wb_data_q;
  assign wb_rd_idx_out = wb_rd_q;
  assign wb_reg_write_enable_out = wb_we_q;
  assign jump_enable_out = jen_q;
  assign jump_address_out = jaddr_q;
  assign mem_error_out = err_q;
endmodule

// File: tb/tb_stage_4_mem.sv
// tb_stage_4_mem: scoreboard bench for stage_4_mem (main instance plus a WAIT_LIMIT=4 instance)
module tb_stage_4_mem;
  logic clk = 1'b0, reset = 1'b0;
  logic [31:0] alu_res, rs2_val, jump_address, mem_rdata;
  logic [4:0] rd_idx;
  logic mem_load_enable, mem_store_enable, reg_write_enable, jump_enable;
  logic mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic mem_req, mem_we, stall_out, wb_reg_write_enable_out, jump_enable_out, mem_error_out;
  logic [31:0] mem_addr, mem_wdata, wb_data_out, jump_address_out;
  logic [4:0] wb_rd_idx_out;
  logic [31:0] b_alu, b_rs2, b_ja, b_rdata;
  logic [4:0] b_rd;
  logic b_load, b_store, b_rwe, b_jen, b_gnt, b_rvalid;
  logic b_req, b_we, b_stall, b_wbwe, b_jen_o, b_err;
  logic [31:0] b_addr, b_wdata, b_wb_data, b_ja_o;
  logic [4:0] b_wb_rd;
  int total = 0, bad = 0;
  int req_hi = 0, b_req_hi = 0, b_wb_cnt = 0;
  int gnt_dly = 0, rv_dly = 1, req_cyc = 0, wait_cyc = 0;
  bit waiting = 1'b0;
  logic [31:0] rd_cfg = '0;
  typedef struct {logic [4:0] rd; logic [31:0] data;} wb_t;
  typedef struct {logic we; logic [31:0] addr; logic [31:0] wdata;} req_t;
  wb_t exp_wb[$];
  req_t exp_req[$];
  wb_t w;
  req_t r;

  stage_4_mem dut (
    .clk(clk), .reset(reset), .alu_res(alu_res), .rs2_val(rs2_val), .rd_idx(rd_idx),
    .mem_load_enable(mem_load_enable), .mem_store_enable(mem_store_enable),
    .reg_write_enable(reg_write_enable), .jump_enable(jump_enable), .jump_address(jump_address),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .stall_out(stall_out),
    .wb_data_out(wb_data_out), .wb_rd_idx_out(wb_rd_idx_out),
    .wb_reg_write_enable_out(wb_reg_write_enable_out), .jump_enable_out(jump_enable_out),
    .jump_address_out(jump_address_out), .mem_error_out(mem_error_out)
  );

  stage_4_mem #(.WAIT_LIMIT(4)) dut_b (
    .clk(clk), .reset(reset), .alu_res(b_alu), .rs2_val(b_rs2), .rd_idx(b_rd),
    .mem_load_enable(b_load), .mem_store_enable(b_store),
    .reg_write_enable(b_rwe), .jump_enable(b_jen), .jump_address(b_ja),
    .mem_req(b_req), .mem_we(b_we), .mem_addr(b_addr), .mem_wdata(b_wdata),
    .mem_gnt(b_gnt), .mem_rvalid(b_rvalid), .mem_rdata(b_rdata), .stall_out(b_stall),
    .wb_data_out(b_wb_data), .wb_rd_idx_out(b_wb_rd),
    .wb_reg_write_enable_out(b_wbwe), .jump_enable_out(b_jen_o),
    .jump_address_out(b_ja_o), .mem_error_out(b_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_wb(input logic [4:0] rd, input logic [31:0] data);
    wb_t e;
    e.rd = rd;
    e.data = data;
    exp_wb.push_back(e);
  endtask

  task automatic push_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    req_t e;
    e.we = we;
    e.addr = addr;
    e.wdata = wdata;
    exp_req.push_back(e);
  endtask

  task automatic nop();
    mem_load_enable = 0; mem_store_enable = 0; reg_write_enable = 0; jump_enable = 0;
    alu_res = '0; rs2_val = '0; jump_address = '0; rd_idx = '0;
  endtask

  // acts as stage 3: present one instruction, hold it while stalled, then drop to a NOP
  task automatic issue(input logic ld, input logic st, input logic rwe, input logic jen,
                       input logic [31:0] alu, input logic [31:0] rs2, input logic [31:0] ja,
                       input logic [4:0] rd, output int stalls);
    @(posedge clk);
    mem_load_enable = ld; mem_store_enable = st; reg_write_enable = rwe; jump_enable = jen;
    alu_res = alu; rs2_val = rs2; jump_address = ja; rd_idx = rd;
    stalls = 0;
    #1;
    while (stall_out && stalls < 40) begin
      stalls++;
      @(posedge clk);
      #1;
    end
    if (stall_out) begin
      total++; bad++;
      $display("FAIL stall_timeout: stall_out still 1 after %0d cycles, required 0", stalls);
    end
    @(negedge clk);
    @(posedge clk);
    nop();
  endtask

  // data-memory responder: grant after gnt_dly REQ cycles, load data rv_dly cycles after grant
  always @(posedge clk) begin
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    if (reset) begin
      waiting = 1'b0;
      req_cyc = 0;
    end else begin
      if (waiting) begin
        wait_cyc++;
        if (wait_cyc == rv_dly) begin
          mem_rvalid = 1'b1; mem_rdata = rd_cfg; waiting = 1'b0;
        end
      end
      if (mem_req) begin
        if (req_cyc == gnt_dly) begin
          mem_gnt = 1'b1;
          if (!mem_we) begin
            if (rv_dly == 0) begin
              mem_rvalid = 1'b1; mem_rdata = rd_cfg;
            end else begin
              waiting = 1'b1; wait_cyc = 0;
            end
          end
        end
        req_cyc++;
      end else req_cyc = 0;
    end
  end

  // monitor: pops the scoreboard whenever the DUT grants a request or strobes writeback
  always @(posedge clk) begin
    #2;
    if (!reset) begin
      if (mem_req) req_hi++;
      if (b_req) b_req_hi++;
      if (b_wbwe) b_wb_cnt++;
      if (mem_req && mem_gnt) begin
        if (exp_req.size() == 0) begin
          total++; bad++;
          $display("FAIL req_unexpected: addr 0x%08h we %0d, required no request", mem_addr, mem_we);
        end else begin
          r = exp_req.pop_front();
          chk("req_we", mem_we, r.we);
          chk("req_addr", mem_addr, r.addr);
          if (r.we) chk("req_wdata", mem_wdata, r.wdata);
        end
      end
      if (wb_reg_write_enable_out) begin
        if (exp_wb.size() == 0) begin
          total++; bad++;
          $display("FAIL wb_unexpected: rd %0d data 0x%08h, required no strobe", wb_rd_idx_out, wb_data_out);
        end else begin
          w = exp_wb.pop_front();
          chk("wb_data", wb_data_out, w.data);
          chk("wb_rd", wb_rd_idx_out, w.rd);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int s, r0;
    nop();
    b_alu = '0; b_rs2 = '0; b_ja = '0; b_rdata = '0; b_rd = '0;
    b_load = 0; b_store = 0; b_rwe = 0; b_jen = 0; b_gnt = 0; b_rvalid = 0;
    #1 reset = 1'b1;
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_stall", stall_out, 0);
    chk("rst_wb_we", wb_reg_write_enable_out, 0);
    chk("rst_err", mem_error_out, 0);
    chk("rst_addr", mem_addr, 0);
    @(posedge clk); @(posedge clk); #1 reset = 1'b0;
    // plain ALU op
    push_wb(5'd5, 32'h10);
    issue(0, 0, 1, 0, 32'h10, 0, 0, 5'd5, s);
    chk("t1_stall", s, 0);
    // ALU op carrying a taken jump
    issue(0, 0, 0, 1, 32'h20, 0, 32'h8000, 5'd6, s);
    #3;
    chk("jmp_en", jump_enable_out, 1);
    chk("jmp_addr", jump_address_out, 32'h8000);
    chk("jmp_wb_we", wb_reg_write_enable_out, 0);
    // load: grant after 2 cycles, data 3 cycles later
    gnt_dly = 2; rv_dly = 3; rd_cfg = 32'hDEADBEEF; r0 = req_hi;
    push_req(0, 32'h100, 0);
    push_wb(5'd8, 32'hDEADBEEF);
    issue(1, 0, 1, 0, 32'h100, 0, 0, 5'd8, s);
    chk("t2_stall", s, 7);
    chk("t2_req_cycles", req_hi - r0, 3);
    // load whose rvalid comes with the grant
    gnt_dly = 1; rv_dly = 0; rd_cfg = 32'hCAFEF00D; r0 = req_hi;
    push_req(0, 32'h104, 0);
    push_wb(5'd10, 32'hCAFEF00D);
    issue(1, 0, 1, 0, 32'h104, 0, 0, 5'd10, s);
    chk("rvg_stall", s, 3);
    chk("rvg_req_cycles", req_hi - r0, 2);
    // store granted on the first REQ cycle; reg write enable must be masked
    gnt_dly = 0; r0 = req_hi;
    push_req(1, 32'h40, 32'h1234);
    issue(0, 1, 1, 0, 32'h40, 32'h1234, 0, 5'd11, s);
    chk("t3_stall", s, 2);
    chk("t3_req_cycles", req_hi - r0, 1);
    // misaligned load
    r0 = req_hi;
    issue(1, 0, 1, 0, 32'h102, 0, 0, 5'd9, s);
    chk("t4_stall", s, 1);
    chk("t4_req_cycles", req_hi - r0, 0);
    #3;
    chk("t4_err", mem_error_out, 1);
    push_wb(5'd12, 32'h77);
    issue(0, 0, 1, 0, 32'h77, 0, 0, 5'd12, s);
    chk("t4_resume_stall", s, 0);
    #3;
    chk("t4_err_sticky", mem_error_out, 1);
    // timeout on the WAIT_LIMIT=4 instance, grant never comes
    @(posedge clk);
    b_load = 1; b_alu = 32'h200; b_rwe = 1; b_rd = 5'd7; s = 0;
    #1;
    while (b_stall && s < 40) begin
      s++;
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    @(posedge clk);
    b_load = 0; b_alu = '0; b_rwe = 0; b_rd = '0;
    #3;
    chk("t5_stall", s, 5);
    chk("t5_req_cycles", b_req_hi, 4);
    chk("t5_err", b_err, 1);
    chk("t5_addr", b_addr, 32'h200);
    @(posedge clk);
    b_rvalid = 1; b_rdata = 32'hBAD0BAD0;
    @(posedge clk);
    b_rvalid = 0;
    repeat (2) @(posedge clk);
    #3;
    chk("t5_late_wb", b_wb_cnt, 0);
    chk("t5_late_data", b_wb_data, 0);
    chk("t5_late_err", b_err, 1);
    chk("t5_late_stall", b_stall, 0);
    // reset while a load sits in WAIT
    gnt_dly = 0; rv_dly = 100;
    push_req(0, 32'h300, 0);
    @(posedge clk);
    mem_load_enable = 1; reg_write_enable = 1; alu_res = 32'h300; rd_idx = 5'd3;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("t6_mem_req", mem_req, 0);
    chk("t6_stall", stall_out, 0);
    chk("t6_addr", mem_addr, 0);
    chk("t6_wb_we", wb_reg_write_enable_out, 0);
    chk("t6_err", mem_error_out, 0);
    chk("t6_b_err", b_err, 0);
    nop();
    @(posedge clk); @(posedge clk); #1 reset = 1'b0;
    push_wb(5'd4, 32'h55);
    issue(0, 0, 1, 0, 32'h55, 0, 0, 5'd4, s);
    chk("t6_after_stall", s, 0);
    repeat (3) @(posedge clk);
    #3;
    chk("wb_queue_left", exp_wb.size(), 0);
    chk("req_queue_left", exp_req.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
